// File: rtl/tatsujin_pkg.sv
// Shared types and constants for the rhythm-game note path.
package tatsujin_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPrefetch,
    StRun,
    StPaused,
    StDrain,
    StDone
  } state_e;

  localparam int unsigned LANE_DON = 0;
  localparam int unsigned LANE_KA  = 1;

  // Lane-select width; a single-lane build still needs a 1-bit select.
  function automatic int unsigned lane_w(input int unsigned lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/note_scroller_if.sv
// Song ROM fetch bus plus the player-hit request/judgement signals.
interface note_scroller_if import tatsujin_pkg::*; #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned ADDR_W = 7
);
  localparam int unsigned LaneW = lane_w(LANES);

  logic [ADDR_W-1:0] rom_addr;
  logic [LANES-1:0]  rom_data;
  logic              hit_valid;
  logic [LaneW-1:0]  hit_lane;
  logic              hit_ok;
  logic              hit_bad;
  logic [LANES-1:0]  miss_mask;

  modport master (
    output rom_addr, hit_ok, hit_bad, miss_mask,
    input  rom_data, hit_valid, hit_lane
  );

  modport slave (
    input  rom_addr, hit_ok, hit_bad, miss_mask,
    output rom_data, hit_valid, hit_lane
  );

endinterface

// File: rtl/note_window_shift.sv
// LANES x WINDOW note register: shift-in at the far edge, hit clear and exit mask at column 0.
module note_window_shift #(
  parameter int unsigned LANES  = 2,
  parameter int unsigned WINDOW = 10
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      shift_en,
  input  logic [LANES-1:0]          shift_col,
  input  logic [LANES-1:0]          clear_mask,
  output logic [LANES*WINDOW-1:0]   window,
  output logic [LANES-1:0]          miss_mask
);

  logic [LANES*WINDOW-1:0] win_q, win_d;
  logic [LANES-1:0]        miss_q, miss_d;
  logic [LANES-1:0]        col0;

  always_comb begin
    win_d  = win_q;
    miss_d = '0;
    col0   = '0;
    for (int l = 0; l < LANES; l++) begin
      col0[l] = win_q[l*WINDOW];
    end
    if (shift_en) begin
      // A note cleared by a same-cycle hit must not also count as a miss.
      miss_d = col0 & ~clear_mask;
      for (int l = 0; l < LANES; l++) begin
        for (int c = 0; c < WINDOW - 1; c++) begin
          win_d[l*WINDOW+c] = win_q[l*WINDOW+c+1];
        end
        win_d[l*WINDOW+WINDOW-1] = shift_col[l];
      end
    end else begin
      for (int l = 0; l < LANES; l++) begin
        if (clear_mask[l]) win_d[l*WINDOW] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      win_q  <= '0;
      miss_q <= '0;
    end else begin
      win_q  <= win_d;
      miss_q <= miss_d;
    end
  end

  assign window    = win_q;
  assign miss_mask = miss_q;

endmodule

// File: rtl/note_scroller.sv
// Multi-lane song scroller: ROM fetch, scroll FSM with pause/drain, and hit judging.
module note_scroller import tatsujin_pkg::*; #(
  parameter int unsigned LANES    = 2,
  parameter int unsigned WINDOW   = 10,
  parameter int unsigned SONG_LEN = 100,
  parameter int unsigned ADDR_W   = 7
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    step_tick,
  note_scroller_if.master         bus,
  output logic [LANES*WINDOW-1:0] window,
  output logic                    busy,
  output logic                    done
);

  localparam int unsigned       DrainW    = $clog2(WINDOW + 1);
  localparam logic [ADDR_W-1:0] SongLast  = ADDR_W'(SONG_LEN - 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(WINDOW - 1);

  state_e              state_q, state_d;
  logic                from_drain_q, from_drain_d;
  logic [ADDR_W-1:0]   song_ptr_q, song_ptr_d;
  logic [LANES-1:0]    next_col_q, next_col_d;
  logic                fetch_pending_q, fetch_pending_d;
  logic                fetch_wait_q, fetch_wait_d;
  logic                step_pending_q, step_pending_d;
  logic [DrainW-1:0]   drain_cnt_q, drain_cnt_d;
  logic                hit_ok_q, hit_ok_d;
  logic                hit_bad_q, hit_bad_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                    fetch_done;
  logic                    shift_en;
  logic [LANES-1:0]        shift_col;
  logic [LANES-1:0]        clear_mask;
  logic [LANES-1:0]        lane_onehot;
  logic [LANES-1:0]        col0;
  logic [LANES*WINDOW-1:0] win;
  logic [LANES-1:0]        miss;

  // The ROM registers rom_addr one edge after we drive it; data is captured the edge after that.
  assign fetch_done = fetch_pending_q & ~fetch_wait_q;

  always_comb begin
    lane_onehot = '0;
    col0        = '0;
    for (int l = 0; l < LANES; l++) begin
      lane_onehot[l] = (int'(bus.hit_lane) == l);
      col0[l]        = win[l*WINDOW];
    end
  end

  always_comb begin
    state_d         = state_q;
    from_drain_d    = from_drain_q;
    song_ptr_d      = song_ptr_q;
    next_col_d      = next_col_q;
    fetch_pending_d = fetch_pending_q;
    fetch_wait_d    = 1'b0;
    step_pending_d  = step_pending_q;
    drain_cnt_d     = drain_cnt_q;
    hit_ok_d        = 1'b0;
    hit_bad_d       = 1'b0;
    shift_en        = 1'b0;
    shift_col       = '0;
    clear_mask      = '0;

    if (fetch_done) begin
      fetch_pending_d = 1'b0;
      next_col_d      = bus.rom_data;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d         = StPrefetch;
          song_ptr_d      = '0;
          fetch_pending_d = 1'b1;
          fetch_wait_d    = 1'b1;
          step_pending_d  = 1'b0;
          drain_cnt_d     = '0;
        end
      end
      StPrefetch: begin
        if (fetch_done) state_d = StRun;
      end
      StPaused: begin
        if (!pause) state_d = from_drain_q ? StDrain : StRun;
      end
      StRun, StDrain: begin
        if (pause) begin
          state_d      = StPaused;
          from_drain_d = (state_q == StDrain);
        end else begin
          if (bus.hit_valid) begin
            if (|(lane_onehot & col0)) begin
              clear_mask = lane_onehot;
              hit_ok_d   = 1'b1;
            end else begin
              hit_bad_d  = 1'b1;
            end
          end
          if (fetch_pending_q && !fetch_done) begin
            if (step_tick) step_pending_d = 1'b1;
          end else if (step_tick || step_pending_q) begin
            shift_en       = 1'b1;
            step_pending_d = 1'b0;
            if (state_q == StRun) begin
              // On the completion edge next_col is not yet loaded, so bypass from the ROM.
              shift_col = fetch_done ? bus.rom_data : next_col_q;
              if (song_ptr_q == SongLast) begin
                state_d     = StDrain;
                drain_cnt_d = '0;
              end else begin
                song_ptr_d      = song_ptr_q + ADDR_W'(1);
                fetch_pending_d = 1'b1;
                fetch_wait_d    = 1'b1;
              end
            end else begin
              drain_cnt_d = drain_cnt_q + DrainW'(1);
              if (drain_cnt_q == DrainLast) state_d = StDone;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase

    busy_d = state_d inside {StPrefetch, StRun, StPaused, StDrain};
    done_d = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= StIdle;
      from_drain_q    <= 1'b0;
      song_ptr_q      <= '0;
      next_col_q      <= '0;
      fetch_pending_q <= 1'b0;
      fetch_wait_q    <= 1'b0;
      step_pending_q  <= 1'b0;
      drain_cnt_q     <= '0;
      hit_ok_q        <= 1'b0;
      hit_bad_q       <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      from_drain_q    <= from_drain_d;
      song_ptr_q      <= song_ptr_d;
      next_col_q      <= next_col_d;
      fetch_pending_q <= fetch_pending_d;
      fetch_wait_q    <= fetch_wait_d;
      step_pending_q  <= step_pending_d;
      drain_cnt_q     <= drain_cnt_d;
      hit_ok_q        <= hit_ok_d;
      hit_bad_q       <= hit_bad_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
    end
  end

  note_window_shift #(
    .LANES  (LANES),
    .WINDOW (WINDOW)
  ) u_window (
    .clk        (clk),
    .resetn     (resetn),
    .shift_en   (shift_en),
    .shift_col  (shift_col),
    .clear_mask (clear_mask),
    .window     (win),
    .miss_mask  (miss)
  );

  assign bus.rom_addr  = song_ptr_q;
  assign bus.hit_ok    = hit_ok_q;
  assign bus.hit_bad   = hit_bad_q;
  assign bus.miss_mask = miss;
  assign window        = win;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_note_scroller.sv
// Scoreboard bench for note_scroller: column-queue reference model, pulse monitor, directed + random play.
module tb_note_scroller;
  import tatsujin_pkg::*;

  localparam int unsigned LANES    = 2;
  localparam int unsigned WINDOW   = 10;
  localparam int unsigned SONG_LEN = 100;
  localparam int unsigned ADDR_W   = 7;
  localparam int unsigned WW       = LANES * WINDOW;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic start = 1'b0;
  logic pause = 1'b0;
  logic step_tick = 1'b0;
  logic [WW-1:0]    window;
  logic             busy, done;
  logic [LANES-1:0] rom_q = '0;
  logic [LANES-1:0] song [SONG_LEN];

  note_scroller_if #(.LANES(LANES), .ADDR_W(ADDR_W)) bus ();

  note_scroller #(
    .LANES(LANES), .WINDOW(WINDOW), .SONG_LEN(SONG_LEN), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .pause(pause), .step_tick(step_tick),
    .bus(bus), .window(window), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous song ROM: one registered read per clock.
  always @(posedge clk)
    rom_q <= (int'(bus.rom_addr) < int'(SONG_LEN)) ? song[bus.rom_addr] : '0;
  assign bus.rom_data = rom_q;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the window is a queue of columns, index 0 = hit zone.
  int               m_st;  // 0 idle, 1 prefetch, 2 run, 3 paused, 4 drain, 5 done
  bit               m_from_drain;
  bit [LANES-1:0]   m_win[$];
  int               m_loaded, m_wait, m_drained;
  bit               m_defer;
  bit               exp_hit_q[$];
  bit [LANES-1:0]   exp_miss_q[$];

  task automatic model_reset();
    m_st = 0; m_from_drain = 0; m_loaded = 0; m_wait = 0; m_drained = 0; m_defer = 0;
    m_win = {};
    repeat (WINDOW) m_win.push_back('0);
    exp_hit_q = {};
    exp_miss_q = {};
  endtask

  // Predict what the coming clock edge does, given the inputs now driven.
  task automatic model_step();
    bit fetch_busy, completing;
    int lane;
    bit [LANES-1:0] c0;
    fetch_busy = (m_wait > 0);
    completing = (m_wait == 1);
    if (m_wait > 0) m_wait--;
    case (m_st)
      0, 5: if (start) begin
        m_st = 1; m_loaded = 0; m_wait = 2; m_defer = 0; m_drained = 0;
      end
      1: if (completing) m_st = 2;
      3: if (!pause) m_st = m_from_drain ? 4 : 2;
      2, 4: begin
        if (pause) begin
          m_from_drain = (m_st == 4);
          m_st = 3;
        end else begin
          c0 = m_win[0];
          if (bus.hit_valid) begin
            lane = int'(bus.hit_lane);
            if (lane < int'(LANES) && c0[lane]) begin
              c0[lane] = 1'b0;
              m_win[0] = c0;
              exp_hit_q.push_back(1'b1);
            end else begin
              exp_hit_q.push_back(1'b0);
            end
          end
          if (fetch_busy && !completing) begin
            if (step_tick) m_defer = 1;
          end else if (step_tick || m_defer) begin
            m_defer = 0;
            if (c0 != '0) exp_miss_q.push_back(c0);
            void'(m_win.pop_front());
            if (m_st == 2) begin
              m_win.push_back(song[m_loaded]);
              m_loaded++;
              if (m_loaded == int'(SONG_LEN)) begin
                m_st = 4; m_drained = 0;
              end else begin
                m_wait = 2;
              end
            end else begin
              m_win.push_back('0);
              m_drained++;
              if (m_drained == int'(WINDOW)) m_st = 5;
            end
          end
        end
      end
      default: ;
    endcase
  endtask

  function automatic logic [WW-1:0] m_window();
    logic [WW-1:0] w;
    w = '0;
    for (int c = 0; c < int'(WINDOW); c++)
      for (int l = 0; l < int'(LANES); l++) w[l*WINDOW+c] = m_win[c][l];
    return w;
  endfunction

  function automatic int m_addr();
    return (m_loaded < int'(SONG_LEN)) ? m_loaded : int'(SONG_LEN) - 1;
  endfunction

  task automatic check_state();
    chk("window", window, m_window());
    chk("rom_addr", bus.rom_addr, m_addr());
    chk("busy", busy, (m_st >= 1 && m_st <= 4));
    chk("done", done, (m_st == 5));
  endtask

  task automatic drive(input bit s, input bit p, input bit t, input bit h, input int lane);
    start = s; pause = p; step_tick = t; bus.hit_valid = h; bus.hit_lane = 1'(lane);
    model_step();
    @(posedge clk);
    #2;
    check_state();
    start = 0; step_tick = 0; bus.hit_valid = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, pause, 0, 0, 0);
  endtask

  function automatic logic [1:0] col_at(input int c);
    return {window[WINDOW+c], window[c]};
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents a pulse.
  initial begin
    bit e_hit;
    bit [LANES-1:0] e_miss;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (bus.hit_ok || bus.hit_bad) begin
          if (exp_hit_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL hit_pulse: got ok=%0b bad=%0b, expected no pulse (t=%0t)",
                     bus.hit_ok, bus.hit_bad, $time);
          end else begin
            e_hit = exp_hit_q.pop_front();
            chk("hit_pulse", {bus.hit_ok, bus.hit_bad}, e_hit ? 2'b10 : 2'b01);
          end
        end
        if (bus.miss_mask != '0) begin
          if (exp_miss_q.size() == 0) begin
            n_cmp++; n_fail++;
            $display("FAIL miss_mask: got %0b, expected no pulse (t=%0t)", bus.miss_mask, $time);
          end else begin
            e_miss = exp_miss_q.pop_front();
            chk("miss_mask", bus.miss_mask, e_miss);
          end
        end
      end
    end
  end

  initial begin
    logic [WW-1:0]     saved_win;
    logic [ADDR_W-1:0] saved_addr;
    int                guard;

    bus.hit_valid = 0;
    bus.hit_lane = '0;
    model_reset();
    for (int k = 0; k < int'(SONG_LEN); k++) song[k] = {k[0], ~k[0]};

    repeat (2) @(posedge clk);
    #2;
    chk("rst_window", window, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pulses", {bus.hit_ok, bus.hit_bad, bus.miss_mask}, 0);
    resetn = 1;

    // Ten well-spaced ticks fill the window with columns 0..9.
    drive(1, 0, 0, 0, 0);
    idle(3);
    repeat (10) begin
      drive(0, 0, 1, 0, 0);
      idle(3);
    end
    chk("fill_col9", col_at(WINDOW - 1), 2'b10);
    chk("fill_col0", col_at(0), 2'b01);
    chk("fill_rom_addr", bus.rom_addr, 10);
    chk("fill_busy", busy, 1);

    // Good hit clears the note; wrong lane is bad and the note later misses.
    drive(0, 0, 0, 1, LANE_DON);
    chk("hit_cleared", col_at(0), 2'b00);
    idle(3);
    drive(0, 0, 1, 0, 0); idle(3);
    drive(0, 0, 1, 0, 0); idle(3);
    chk("col0_before_bad", col_at(0), 2'b01);
    drive(0, 0, 0, 1, LANE_KA);
    idle(2);
    drive(0, 0, 1, 0, 0); idle(3);
    drive(0, 0, 1, 0, 0); idle(3);
    // Hit and step on the same edge.
    chk("col0_before_both", col_at(0), 2'b01);
    drive(0, 0, 1, 1, LANE_DON);
    idle(3);

    // Back-to-back ticks: second is deferred, third dropped.
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 0);
    idle(4);
    chk("b2b_rom_addr", bus.rom_addr, 17);
    chk("b2b_col0", col_at(0), 2'b10);

    // Paused: ticks and hits are ignored.
    drive(0, 1, 0, 0, 0);
    saved_win = window;
    saved_addr = bus.rom_addr;
    for (int i = 0; i < 20; i++) drive(0, 1, (i % 4 == 1), (i % 7 == 2), i % 2);
    chk("pause_window", window, saved_win);
    chk("pause_rom_addr", bus.rom_addr, saved_addr);
    drive(0, 0, 0, 0, 0);
    idle(2);
    drive(0, 0, 1, 0, 0);
    idle(3);
    chk("resume_rom_addr", bus.rom_addr, 18);

    // Random play to the end of the song.
    guard = 0;
    while (m_st != 5 && guard < 20000) begin
      drive(0, ($urandom_range(0, 40) == 0) ? ~pause : pause,
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0), $urandom_range(0, 1));
      guard++;
    end
    pause = 0;
    idle(2);
    chk("end_done", done, 1);
    chk("end_busy", busy, 0);
    chk("end_window", window, 0);

    // Restart from DONE with a random song, then abort mid-run.
    for (int k = 0; k < int'(SONG_LEN); k++) song[k] = LANES'($urandom);
    drive(1, 0, 0, 0, 0);
    repeat (150) drive(0, 0, ($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                       $urandom_range(0, 1));
    @(negedge clk);
    #1;
    chk("hit_q_drained", exp_hit_q.size(), 0);
    chk("miss_q_drained", exp_miss_q.size(), 0);
    chk("mid_run_busy", busy, 1);
    resetn = 0;
    #1;
    chk("arst_window", window, 0);
    chk("arst_rom_addr", bus.rom_addr, 0);
    chk("arst_busy_done", {busy, done}, 0);
    chk("arst_pulses", {bus.hit_ok, bus.hit_bad, bus.miss_mask}, 0);
    model_reset();
    @(posedge clk);
    #2;
    resetn = 1;
    idle(2);

    // Back from IDLE after the abort.
    drive(1, 0, 0, 0, 0);
    idle(3);
    repeat (3) begin
      drive(0, 0, 1, 0, 0);
      idle(3);
    end
    chk("restart_rom_addr", bus.rom_addr, 3);
    @(negedge clk);
    #1;
    chk("final_hit_q", exp_hit_q.size(), 0);
    chk("final_miss_q", exp_miss_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/note_scroller.md
Name: note_scroller

Overview:
- Multi-lane successor to the single-lane song shifter for the rhythm game.
- Streams a song from a synchronous ROM, one column per scroll tick, into a visible note window that the square-picking/drawing logic renders.
- Judges player hits against the hit-zone column and reports hit, bad and miss pulses to the score logic.
- Adds start, pause, end-of-song drain and done handling, none of which the single-lane shifter has.

Parameters:
- LANES, 2, note lanes per column (lane 0 = don, lane 1 = ka).
- WINDOW, 10, visible columns; column 0 is the hit zone.
- SONG_LEN, 100, song length in columns.
- ADDR_W, 7, ROM address width; must satisfy 2^ADDR_W >= SONG_LEN.

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- resetn  in  1  asynchronous active-low reset.
- start  in  1  pulse; begins the song from IDLE or DONE.
- pause  in  1  level; freezes scrolling and judging while high.
- step_tick  in  1  one-cycle scroll pulse from the rate divider.
- rom_addr  out  ADDR_W  song ROM address.
- rom_data  in  LANES  ROM column; valid 1 cycle after rom_addr.
- hit_valid  in  1  pulse; player pressed a key.
- hit_lane  in  $clog2(LANES)  lane of the press.
- window  out  LANES*WINDOW  note bit for lane l, column c at index l*WINDOW+c.
- hit_ok  out  1  pulse; the press cleared a note.
- hit_bad  out  1  pulse; the press found no note.
- miss_mask  out  LANES  per-lane pulse; an unhit note left column 0.
- busy  out  1  high in PREFETCH, RUN, PAUSED, DRAIN.
- done  out  1  high in DONE.

Behaviour:
- Reset, asynchronous: state=IDLE; window, rom_addr, song_ptr, next_col, all pulses, busy and done are 0.
- All outputs are registered. Pulses are one cycle wide and appear the cycle after the causing input.
- States:
  - IDLE: start -> PREFETCH, with song_ptr=0.
  - PREFETCH: waits 1 cycle for rom_data at ptr 0, latches it into next_col, then -> RUN.
  - RUN: pause=1 -> PAUSED. On an accepted step:
    - window shifts toward column 0;
    - column WINDOW-1 <= next_col;
    - song_ptr++ and a fetch is issued (rom_addr=song_ptr, fetch_pending=1);
    - if the column just loaded was index SONG_LEN-1 -> DRAIN.
  - PAUSED: pause=0 -> returns to RUN or DRAIN, whichever it came from. step_tick and hit_valid are ignored (no pulses). A fetch already in flight still completes.
  - DRAIN: each accepted step shifts in an all-zero column. After WINDOW drain steps -> DONE.
  - DONE: done=1, busy=0, window all 0. start -> PREFETCH.
- Fetch timing:
  - next_col captures rom_data the cycle after rom_addr changes, then fetch_pending clears.
  - A step_tick arriving while fetch_pending=1 is latched in step_pending and applied on the cycle the fetch completes.
  - A second tick while step_pending=1 is dropped.
- Exit/miss: on each step, miss_mask = (column 0 before the shift, after any same-cycle hit clear) per lane. Active in both RUN and DRAIN.
- Hit judging, RUN or DRAIN only:
  - window bit (hit_lane, column 0) = 1: clear it, hit_ok.
  - Otherwise: hit_bad.
  - hit_lane >= LANES counts as hit_bad.
- Simultaneous hit and step: the hit is judged against column 0 before the shift. A cleared note produces no miss for that lane.
- start while busy is ignored. resetn low mid-song aborts everything to the reset values.
- Width rules: song_ptr is ADDR_W bits and never exceeds SONG_LEN-1. The drain counter is $clog2(WINDOW+1) bits.

Decomposition:
- Shared package (tatsujin_pkg): the state enum (IDLE, PREFETCH, RUN, PAUSED, DRAIN, DONE) and lane constants (LANE_DON=0, LANE_KA=1).
- One sub-module, note_window_shift: holds the LANES x WINDOW register array and performs shift-in, column-0 clear and exit-mask generation.
- The top level holds the FSM, fetch/step_pending logic and hit judging.

Test Plan:
- Reset, then start; ROM column k = {k[0], ~k[0]} (lane 1 = k[0], lane 0 = ~k[0]); 10 ticks 4 cycles apart -> window column 9 = ROM col 9 = 2'b10, column 0 = col 0 = 2'b01, rom_addr=10, busy=1.
- Same setup, hit_valid lane 0 when column 0 = 2'b01 -> hit_ok next cycle, bit cleared, no miss_mask at the next step. Hit lane 1 instead -> hit_bad, and the next step gives miss_mask=2'b01.
- Hit and step_tick in the same cycle with column 0 = 2'b01, hit lane 0 -> hit_ok, miss_mask=0, window shifted.
- step_tick issued on consecutive cycles -> second tick deferred via step_pending, applied when the fetch completes; a third back-to-back tick is dropped; window content stays in correct ROM order.
- pause held for 20 cycles with 5 ticks and 3 hits -> window unchanged, no pulses. Release -> scrolling resumes at the same rom_addr.
- SONG_LEN=12, WINDOW=4 -> after 16 accepted steps done=1, busy=0, window=0, and every unhit note produced exactly one miss_mask bit. resetn low mid-RUN -> all outputs 0 asynchronously, state IDLE.
